// File: rtl/my_axil_regbank.sv
// AXI4-Lite register bank: CTRL, W1C event STATUS, read-only ID and general RW words.
`timescale 1ns/1ps
module my_axil_regbank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS           = 16,
  parameter int unsigned N_EVT              = 8,
  parameter logic [31:0] ID_VALUE           = 32'h0002_0100
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [N_EVT-1:0]                  hw_event,
  output logic                              irq
);

  localparam int unsigned DW          = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW          = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB          = DW / 8;
  localparam int unsigned LSB         = $clog2(NB);
  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam int unsigned RANGE_BYTES = NUM_REGS * NB;
  localparam int unsigned IDX_CTRL    = 0;
  localparam int unsigned IDX_STATUS  = 1;
  localparam int unsigned IDX_ID      = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR_HELD,
    W_DATA_HELD,
    W_WRITE,
    W_RESP
  } wstate_e;

  // Byte address falls inside the implemented register window.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < RANGE_BYTES;
  endfunction

  // Expand per-byte strobes into a per-bit mask.
  function automatic logic [DW-1:0] strb_mask(input logic [NB-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) begin
      m[b*8 +: 8] = {8{s[b]}};
    end
    return m;
  endfunction

  // Write channel state
  wstate_e          wstate_q, wstate_d;
  logic [AW-1:0]    awaddr_q, awaddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [NB-1:0]    wstrb_q, wstrb_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  // Read channel state
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  // Register file
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic [DW-1:0]    regs_d [NUM_REGS];
  logic [N_EVT-1:0] status_q, status_d;
  logic [N_EVT-1:0] status_clr_c;
  logic             irq_q, irq_d;

  logic             aw_hs_c, w_hs_c, ar_hs_c;
  logic             wr_in_range_c, wr_fire_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [DW-1:0]    wmask_c;
  logic             rd_in_range_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [DW-1:0]    rd_word_c;
  logic             unused_c;

  assign aw_hs_c       = s00_axi_awvalid & awready_q;
  assign w_hs_c        = s00_axi_wvalid & wready_q;
  assign ar_hs_c       = s00_axi_arvalid & arready_q;
  assign wr_in_range_c = in_range(awaddr_q);
  assign wr_idx_c      = awaddr_q[LSB +: IDX_W];
  assign wr_fire_c     = (wstate_q == W_WRITE) && wr_in_range_c;
  assign wmask_c       = strb_mask(wstrb_q);
  assign rd_in_range_c = in_range(s00_axi_araddr);
  assign rd_idx_c      = s00_axi_araddr[LSB +: IDX_W];
  assign unused_c      = &{1'b0, s00_axi_awprot, s00_axi_arprot};

  // Write FSM next state, channel capture and registered handshake outputs.
  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    if (aw_hs_c) begin
      awaddr_d = s00_axi_awaddr;
    end
    if (w_hs_c) begin
      wdata_d = s00_axi_wdata;
      wstrb_d = s00_axi_wstrb;
    end
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          wstate_d = W_WRITE;
        end else if (aw_hs_c) begin
          wstate_d = W_ADDR_HELD;
        end else if (w_hs_c) begin
          wstate_d = W_DATA_HELD;
        end
      end
      W_ADDR_HELD: begin
        if (w_hs_c) begin
          wstate_d = W_WRITE;
        end
      end
      W_DATA_HELD: begin
        if (aw_hs_c) begin
          wstate_d = W_WRITE;
        end
      end
      W_WRITE: begin
        wstate_d = W_RESP;
        bresp_d  = wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: begin
        if (bvalid_q && s00_axi_bready) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) || (wstate_d == W_DATA_HELD);
    wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_ADDR_HELD);
    bvalid_d  = (wstate_d == W_RESP);
  end

  // Write FSM state register and captured AW/W payload.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wstate_q  <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Register update: strobed RW writes, W1C status with event set winning, irq level.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    status_clr_c = '0;
    if (wr_fire_c) begin
      if (wr_idx_c == IDX_W'(IDX_STATUS)) begin
        status_clr_c = N_EVT'(wdata_q & wmask_c);
      end else if (wr_idx_c != IDX_W'(IDX_ID)) begin
        regs_d[wr_idx_c] = (regs_q[wr_idx_c] & ~wmask_c) | (wdata_q & wmask_c);
      end
    end
    status_d = (status_q & ~status_clr_c) | hw_event;
    irq_d    = regs_q[IDX_CTRL][0] & (|status_q);
  end

  // Register file, status and interrupt flops.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  // Read mux: status zero-extended, ID constant, everything else from the file.
  always_comb begin
    rd_word_c = regs_q[rd_idx_c];
    if (rd_idx_c == IDX_W'(IDX_STATUS)) begin
      rd_word_c = DW'(status_q);
    end else if (rd_idx_c == IDX_W'(IDX_ID)) begin
      rd_word_c = DW'(ID_VALUE);
    end
  end

  // Read channel next state: one-cycle latency, single outstanding read.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range_c ? rd_word_c : '0;
      rresp_d  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = ~rvalid_d;
  end

  // Read channel flops.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign irq             = irq_q;

endmodule

// File: doc/my_axil_regbank.md
MY_AXIL_REGBANK -- requirements
Module: my_axil_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width (32 or 64 only).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count (power of 2, 4..64, NUM_REGS*DW/8 <= 2**ADDR_WIDTH).
REQ-004 SHALL have parameter N_EVT, default 8, event input count (1..DW).
REQ-005 SHALL have parameter ID_VALUE, default 32'h0002_0100, read-only ID word.
REQ-006 s00_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-007 s00_axi_areset  in  1  reset, asynchronous and active-high.
REQ-008 s00_axi_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1; s00_axi_awready  out  1  write-address channel (awprot ignored).
REQ-009 s00_axi_wdata/wstrb/wvalid  in  DW/DW/8/1; s00_axi_wready  out  1  write-data channel.
REQ-010 s00_axi_bresp  out  2, s00_axi_bvalid  out  1, s00_axi_bready  in  1  write response.
REQ-011 s00_axi_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1; s00_axi_arready  out  1  read-address channel (arprot ignored).
REQ-012 s00_axi_rdata  out  DW, s00_axi_rresp  out  2, s00_axi_rvalid  out  1, s00_axi_rready  in  1  read data.
REQ-013 hw_event  in  N_EVT  single-cycle event pulses, synchronous to s00_axi_aclk.
REQ-014 irq  out  1  registered level interrupt.

Function
REQ-015 Register index = addr[log2(DW/8) +: log2(NUM_REGS)]; addresses >= NUM_REGS*DW/8 are out of range; low address bits ignored.
REQ-016 Map: idx0 CTRL RW (bit0 = irq enable); idx1 STATUS W1C, bits[N_EVT-1:0]; idx2 ID read-only = ID_VALUE zero-extended; idx3..NUM_REGS-1 general RW.
REQ-017 RW writes SHALL honour wstrb per byte; STATUS clears only bits set in bytes enabled by wstrb; writes to ID ignored, response OKAY.
REQ-018 Write FSM states: IDLE, ADDR_HELD, DATA_HELD, WRITE, RESP.
REQ-019 awready high in IDLE/DATA_HELD; wready high in IDLE/ADDR_HELD; AW and W accepted in either order or same cycle.
REQ-020 Once both captured -> WRITE: register updated on that edge; next cycle bvalid=1 (RESP).
REQ-021 bresp = 2'b00 OKAY in range, 2'b10 SLVERR out of range (no register changed); bvalid and bresp held until bready; RESP -> IDLE on bvalid&bready.
REQ-022 Single outstanding write: awready=wready=0 in WRITE and RESP.
REQ-023 Read: arready=1 when rvalid=0; on AR handshake rdata/rresp registered, rvalid=1 next cycle (latency 1); held until rready; arready=0 while rvalid=1.
REQ-024 Out-of-range read: rdata=0, rresp=2'b10.
REQ-025 Read and write channels independent; same-cycle read and write to same register returns pre-write value.
REQ-026 STATUS bit set when hw_event bit =1; set and W1C clear on same edge: set wins.
REQ-027 irq next edge = CTRL[0] & (|STATUS).
REQ-028 All register arithmetic width-exact; unused upper bits of STATUS read 0.

Reset
REQ-029 While s00_axi_areset=1: all registers 0, ID reads ID_VALUE, FSM IDLE, all ready/valid outputs 0, bresp=rresp=0, rdata=0, irq=0.
REQ-030 First rising edge after deassertion: awready=wready=arready=1.
REQ-031 Reset mid-transaction aborts it immediately; pending bvalid/rvalid drop to 0; no partial write survives.

Verification
REQ-032 Write 0x1,0x2,0x3 to idx3..5 (wstrb=0xF), read back -> rdata 0x1,0x2,0x3, bresp/rresp OKAY, rvalid one cycle after AR handshake.
REQ-033 Write 0xAABBCCDD to idx3, then 0x11223344 with wstrb=0x5 -> read 0xAA22CC44.
REQ-034 W presented 3 cycles before AW, bready held low 4 cycles -> single write, bvalid held stable, no second accept until bready.
REQ-035 Pulse hw_event=0x05, CTRL=1 -> STATUS 0x05, irq=1; write STATUS 0x01 same cycle as hw_event bit0 -> STATUS stays 0x05; write 0x05 -> STATUS 0, irq=0.
REQ-036 Access address NUM_REGS*4 (DW=32) -> bresp=2'b10, rresp=2'b10, rdata=0, no register changed; read idx2 -> ID_VALUE.
REQ-037 Assert reset with bvalid=1 pending -> bvalid=0 immediately, all registers 0, ready outputs 1 one edge after release.
